// File: rtl/capture_sequencer.sv
// capture_sequencer: decimating multi-channel ADC capture into a circular memory; pre-trigger history under CAPTURE_PRETRIG_EN.
// wr_data is 1 cycle after the last contributing sample; no backpressure, the memory accepts every wr_en.
module capture_sequencer #(
    parameter int NCH      = 8,
    parameter int DW       = 16,
    parameter int AW       = 14,
    parameter int LOG_DMAX = 5
) (
    input  logic                adc_clk,
    input  logic                rst_n,
    input  logic [NCH*DW-1:0]   adc_data,
    input  logic [NCH-1:0]      chan_mask,
    input  logic [4:0]          log_decim,
    input  logic                trig_mode,
    input  logic [AW-1:0]       pretrig,
    input  logic                arm,
    input  logic                ext_trig,
    output logic                wr_en,
    output logic [AW-1:0]       wr_addr,
    output logic [NCH*DW-1:0]   wr_data,
    output logic [NCH-1:0]      wr_mask,
    output logic                running,
    output logic                full,
    output logic [AW-1:0]       trig_ptr,
    output logic [31:0]         status
);

`ifdef CAPTURE_PRETRIG_EN
    localparam bit PRETRIG_EN = 1'b1;
`else
    localparam bit PRETRIG_EN = 1'b0;
`endif

    localparam int ACCW = DW + LOG_DMAX;
    localparam int PW   = (LOG_DMAX > 0) ? LOG_DMAX : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PRE  = 2'd1,
        S_WAIT = 2'd2,
        S_POST = 2'd3
    } state_t;

    state_t                 state;
    logic [4:0]             log_decim_l;
    logic [4:0]             log_decim_c;
    logic                   trig_mode_l;
    logic [AW-1:0]          pretrig_l;
    logic [AW-1:0]          pre_cnt;
    logic [AW:0]            post_cnt;
    logic                   triggered;
    logic                   ext_q;
    logic                   ext_rise;
    logic [PW-1:0]          phase;
    logic [PW-1:0]          dmask;
    logic                   dstb;
    logic signed [ACCW-1:0] acc [NCH];
    logic signed [ACCW-1:0] sum [NCH];
    logic [NCH*DW-1:0]      dec_data;

    always_comb begin
        log_decim_c = (log_decim > 5'(LOG_DMAX)) ? 5'(LOG_DMAX) : log_decim;
    end

    // Phase restarts on arm, so the low log_decim_l bits all-ones marks the last sample of a block.
    assign dmask    = ~({PW{1'b1}} << log_decim_l);
    assign dstb     = ((phase & dmask) == dmask);
    assign ext_rise = ext_trig & ~ext_q;

    always_comb begin
        sum      = '{default: '0};
        dec_data = '0;
        for (int k = 0; k < NCH; k++) begin
            sum[k] = acc[k] + ACCW'(signed'(adc_data[k*DW +: DW]));
            if (wr_mask[k]) begin
                dec_data[k*DW +: DW] = DW'(sum[k] >>> log_decim_l);
            end
        end
    end

    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            phase <= '0;
            ext_q <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                acc[k] <= '0;
            end
        end else begin
            ext_q <= ext_trig;
            phase <= arm ? '0 : phase + 1'b1;
            for (int k = 0; k < NCH; k++) begin
                if (arm || dstb || !wr_mask[k]) begin
                    acc[k] <= '0;
                end else begin
                    acc[k] <= sum[k];
                end
            end
        end
    end

    always_ff @(posedge adc_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            log_decim_l <= '0;
            trig_mode_l <= 1'b0;
            pretrig_l   <= '0;
            pre_cnt     <= '0;
            post_cnt    <= '0;
            triggered   <= 1'b0;
            full        <= 1'b0;
            wr_en       <= 1'b0;
            wr_addr     <= '0;
            wr_data     <= '0;
            wr_mask     <= '0;
            trig_ptr    <= '0;
        end else begin
            wr_en   <= 1'b0;
            wr_addr <= wr_addr + AW'(wr_en);
            if (arm) begin
                wr_mask     <= chan_mask;
                log_decim_l <= log_decim_c;
                trig_mode_l <= trig_mode;
                pretrig_l   <= PRETRIG_EN ? pretrig : '0;
                pre_cnt     <= '0;
                wr_addr     <= '0;
                triggered   <= 1'b0;
                full        <= 1'b0;
                state       <= (PRETRIG_EN && (pretrig != '0)) ? S_PRE : S_WAIT;
            end else begin
                case (state)
                    S_IDLE: begin
                    end
                    S_PRE: begin
                        if (dstb) begin
                            wr_en   <= 1'b1;
                            wr_data <= dec_data;
                            pre_cnt <= pre_cnt + 1'b1;
                            if (pre_cnt == pretrig_l - 1'b1) begin
                                state <= S_WAIT;
                            end
                        end
                    end
                    S_WAIT: begin
                        if (PRETRIG_EN && dstb) begin
                            wr_en   <= 1'b1;
                            wr_data <= dec_data;
                        end
                        if (!trig_mode_l || ext_rise) begin
                            triggered <= 1'b1;
                            post_cnt  <= {1'b1, {AW{1'b0}}} - {1'b0, pretrig_l};
                            state     <= S_POST;
                            // A write issued in this same cycle still belongs to the pre-trigger history.
                            if (PRETRIG_EN) begin
                                trig_ptr <= wr_addr + AW'(wr_en) + AW'(dstb);
                            end
                        end
                    end
                    S_POST: begin
                        if (post_cnt == '0) begin
                            full  <= 1'b1;
                            state <= S_IDLE;
                        end else if (dstb) begin
                            wr_en    <= 1'b1;
                            wr_data  <= dec_data;
                            post_cnt <= post_cnt - 1'b1;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign running = (state != S_IDLE);
    assign status  = {running, full, triggered, state, 3'b000, log_decim_l, 5'b00000, 14'(wr_addr)};

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer: reset, pass-through ramp, decimation, masking, restarts, trigger pointer.
module tb_capture_sequencer;
    localparam int NCH = 8;
    localparam int DW  = 16;
    localparam int AW  = 14;

    logic              adc_clk = 1'b0;
    logic              rst_n;
    logic [NCH*DW-1:0] adc_data;
    logic [NCH-1:0]    chan_mask;
    logic [4:0]        log_decim;
    logic              trig_mode;
    logic [AW-1:0]     pretrig;
    logic              arm;
    logic              ext_trig;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [NCH*DW-1:0] wr_data;
    logic [NCH-1:0]    wr_mask;
    logic              running;
    logic              full;
    logic [AW-1:0]     trig_ptr;
    logic [31:0]       status;

    int checks = 0;
    int errors = 0;

    capture_sequencer #(.NCH(NCH), .DW(DW), .AW(AW), .LOG_DMAX(5)) dut (
        .adc_clk  (adc_clk),
        .rst_n    (rst_n),
        .adc_data (adc_data),
        .chan_mask(chan_mask),
        .log_decim(log_decim),
        .trig_mode(trig_mode),
        .pretrig  (pretrig),
        .arm      (arm),
        .ext_trig (ext_trig),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_mask  (wr_mask),
        .running  (running),
        .full     (full),
        .trig_ptr (trig_ptr),
        .status   (status)
    );

    always #5 adc_clk = ~adc_clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] ramp_vec(input logic [15:0] v);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < NCH; k++) begin
            r[k*16 +: 16] = v + 16'(k * 4099);
        end
        return r;
    endfunction

    initial begin
        int           nw;
        int           addr_err;
        int           data_err;
        int           exp_total;
        int           exp_ptr;
        logic [127:0] prev_drv;
        logic [127:0] exp_v;
        logic [15:0]  v;
        logic         last_wen;
        bit           done;

        rst_n     = 1'b0;
        arm       = 1'b0;
        ext_trig  = 1'b0;
        adc_data  = '0;
        chan_mask = '0;
        log_decim = '0;
        trig_mode = 1'b0;
        pretrig   = '0;
        repeat (2) @(negedge adc_clk);
        check("rst_wr_en", wr_en, 0);
        check("rst_wr_data", wr_data, 0);
        check("rst_status", status, 0);
        rst_n = 1'b1;
        repeat (3) @(negedge adc_clk);
        check("idle_status", status, 0);
        check("idle_outputs", {wr_en, wr_addr, wr_mask, running, full, trig_ptr}, 0);

        // Pass-through ramp, immediate trigger, no pre-trigger history.
        chan_mask = 8'hFF;
        log_decim = 5'd0;
        trig_mode = 1'b0;
        pretrig   = '0;
        arm       = 1'b1;
        v         = 16'd0;
        adc_data  = ramp_vec(v);
        prev_drv  = adc_data;
        @(negedge adc_clk);
        arm = 1'b0;
        check("t1_running", running, 1);
        check("t1_state_wait", status[28:27], 2'd2);
        nw = 0; addr_err = 0; data_err = 0; last_wen = 1'b0; done = 1'b0;
        for (int c = 0; c < 20000 && !done; c++) begin
            if (c > 0) @(negedge adc_clk);
            if (full) begin
                done = 1'b1;
                check("t1_full_after_last_wr", {last_wen, wr_en}, 2'b10);
            end else begin
                if (wr_en) begin
                    if (wr_addr !== nw[13:0]) addr_err++;
                    if (wr_data !== prev_drv) data_err++;
                    nw++;
                end
                last_wen = wr_en;
                v        = v + 16'd1;
                adc_data = ramp_vec(v);
                prev_drv = adc_data;
            end
        end
`ifdef CAPTURE_PRETRIG_EN
        check("t1_writes", nw, 16385);
        check("t1_trig_ptr", trig_ptr, 1);
`else
        check("t1_writes", nw, 16384);
        check("t1_trig_ptr", trig_ptr, 0);
`endif
        check("t1_full", full, 1);
        check("t1_addr_seq", addr_err, 0);
        check("t1_data", data_err, 0);
        check("t1_running_low", running, 0);
        check("t1_triggered", status[29], 1);
        check("t1_state_idle", status[28:27], 0);

        // Decimate by 4: channel 0 sums -1-2-3-4 = -10, >>>2 gives -3.
        log_decim = 5'd2;
        arm       = 1'b1;
        adc_data  = '0;
        adc_data[31:16]   = 16'd5;
        adc_data[111:96]  = 16'h8000;
        adc_data[127:112] = 16'h7FFF;
        adc_data[15:0]    = 16'h1234;
        @(negedge adc_clk);
        arm = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("t2_no_early_wr", wr_en, 0);
            adc_data[15:0] = 16'(-(i + 1));
            @(negedge adc_clk);
        end
        exp_v = '0;
        exp_v[15:0]    = 16'hFFFD;
        exp_v[31:16]   = 16'd5;
        exp_v[111:96]  = 16'h8000;
        exp_v[127:112] = 16'h7FFF;
        check("t2_wr_en", wr_en, 1);
        check("t2_addr0", wr_addr, 0);
        check("t2_data", wr_data, exp_v);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) check("t2_gap", wr_en, 0);
            adc_data[15:0] = 16'(-(i + 1));
            @(negedge adc_clk);
        end
        check("t2_wr_en2", wr_en, 1);
        check("t2_addr1", wr_addr, 1);
        check("t2_data2", wr_data, exp_v);
        check("t2_state_post", status[28:27], 2'd3);

        // Re-arm mid-POST with mask 05 and decimate by 2; later input changes must not take effect.
        chan_mask = 8'h05;
        log_decim = 5'd1;
        arm       = 1'b1;
        for (int k = 0; k < NCH; k++) adc_data[k*16 +: 16] = 16'h1111;
        @(negedge adc_clk);
        arm = 1'b0;
        check("t3_restart", {full, running, wr_en, wr_addr}, {1'b0, 1'b1, 1'b0, 14'd0});
        check("t3_wr_mask", wr_mask, 8'h05);
        check("t3_log_decim", status[23:19], 5'd1);
        adc_data[15:0] = 16'd3;  adc_data[31:16] = 16'd100; adc_data[47:32] = 16'hFFFB;
        @(negedge adc_clk);
        check("t3_no_wr", wr_en, 0);
        adc_data[15:0] = 16'd4;  adc_data[47:32] = 16'hFFFA;
        chan_mask = 8'hFF;
        log_decim = 5'd0;
        @(negedge adc_clk);
        exp_v = '0;
        exp_v[15:0]  = 16'd3;
        exp_v[47:32] = 16'hFFFA;
        check("t3_wr", {wr_en, wr_addr}, {1'b1, 14'd0});
        check("t3_data", wr_data, exp_v);
        adc_data[15:0] = 16'hFFF9; adc_data[47:32] = 16'd1;
        @(negedge adc_clk);
        check("t3_gap", wr_en, 0);
        adc_data[15:0] = 16'hFFF8; adc_data[47:32] = 16'd2;
        @(negedge adc_clk);
        exp_v = '0;
        exp_v[15:0]  = 16'hFFF8;
        exp_v[47:32] = 16'd1;
        check("t3_wr2", {wr_en, wr_addr}, {1'b1, 14'd1});
        check("t3_data2", wr_data, exp_v);
        check("t3_mask_held", {wr_mask, status[23:19]}, {8'h05, 5'd1});

        // External trigger with pre-trigger history; re-arm on the final write.
        trig_mode = 1'b1;
        pretrig   = 14'd100;
        log_decim = 5'd0;
        chan_mask = 8'hFF;
        adc_data  = ramp_vec(16'd0);
        arm       = 1'b1;
`ifdef CAPTURE_PRETRIG_EN
        exp_total = 16784;
        exp_ptr   = 500;
`else
        exp_total = 16384;
        exp_ptr   = 0;
`endif
        @(negedge adc_clk);
        arm = 1'b0;
        nw = 0; addr_err = 0; done = 1'b0;
        for (int c = 0; c < 20000 && !done; c++) begin
            if (c > 0) @(negedge adc_clk);
            if (wr_en) begin
                if (wr_addr !== nw[13:0]) addr_err++;
                nw++;
            end
`ifdef CAPTURE_PRETRIG_EN
            if (c == 0) check("t4_state_pre", status[28:27], 2'd1);
            if (nw == 10) ext_trig = 1'b1;
            if (nw == 20) ext_trig = 1'b0;
            if (wr_en && nw == 400) check("t4_pre_edge_ignored", status[29], 0);
            if (wr_en && wr_addr == 14'd498) ext_trig = 1'b1;
`else
            if (c == 50) begin
                check("t4_wait_no_wr", nw, 0);
                check("t4_wait_state", {status[29], status[28:27]}, 3'b010);
                ext_trig = 1'b1;
            end
`endif
            if (nw == exp_total) done = 1'b1;
        end
        check("t4_writes", nw, exp_total);
        check("t4_addr_seq", addr_err, 0);
        check("t4_trig_ptr", trig_ptr, exp_ptr);
        check("t4_triggered", status[29], 1);
        trig_mode = 1'b0;
        pretrig   = '0;
        ext_trig  = 1'b0;
        arm       = 1'b1;
        @(negedge adc_clk);
        arm = 1'b0;
        check("t5_final_arm_full", full, 0);
        check("t5_restart", {running, wr_en, wr_addr}, {1'b1, 1'b0, 14'd0});
        check("t5_state", {status[29], status[28:27]}, 3'b010);

        // Asynchronous reset in the middle of POST.
        repeat (10) @(negedge adc_clk);
        check("t6_post_writing", {wr_en, status[28:27]}, 3'b111);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_ctrl", {wr_en, wr_addr, wr_mask, running, full, trig_ptr}, 0);
        check("t6_rst_data", wr_data, 0);
        check("t6_rst_status", status, 0);
        @(negedge adc_clk);
        rst_n = 1'b1;

        // Decimation ratio request above the maximum clamps to 32.
        log_decim = 5'd9;
        adc_data  = ramp_vec(16'd0);
        arm       = 1'b1;
        @(negedge adc_clk);
        arm = 1'b0;
        check("t7_clamp", status[23:19], 5'd5);
        nw = 0;
        for (int i = 0; i < 32; i++) begin
            if (wr_en) nw++;
            @(negedge adc_clk);
        end
        check("t7_no_early_wr", nw, 0);
        check("t7_first_wr", {wr_en, wr_addr}, {1'b1, 14'd0});
        check("t7_avg_data", wr_data, ramp_vec(16'd0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
